// File: rtl/depthwise_mac_pkg.sv
// rtl/depthwise_mac_pkg.sv - shared defaults and output scaling helper for depthwise_mac_pipe
package depthwise_mac_pkg;

  localparam int DEF_A_W        = 18;
  localparam int DEF_B_W        = 6;
  localparam int DEF_ACC_W      = 32;
  localparam int DEF_OUT_W      = 18;
  localparam int DEF_NUM_TAPS   = 9;
  localparam int DEF_MUL_STAGES = 3;
  localparam int DEF_SHIFT      = 0;

  // Working width for scaling; wide enough that acc + half-LSB never overflows.
  localparam int RSS_W = 64;

  typedef struct packed {
    logic                    sat;
    logic signed [RSS_W-1:0] data;
  } rss_t;

  function automatic rss_t round_shift_sat(input logic [RSS_W-1:0] acc_bits,
                                           input int acc_w,
                                           input int out_w,
                                           input int shift);
    logic signed [RSS_W-1:0] one;
    logic signed [RSS_W-1:0] v;
    logic signed [RSS_W-1:0] r;
    logic signed [RSS_W-1:0] hi;
    logic signed [RSS_W-1:0] lo;
    rss_t res;
    one = 1;
    v   = $signed(acc_bits << (RSS_W - acc_w)) >>> (RSS_W - acc_w);
    r   = v;
    if (shift > 0) begin
      r = (v + (one <<< (shift - 1))) >>> shift;
    end
    hi       = (one <<< (out_w - 1)) - one;
    lo       = -(one <<< (out_w - 1));
    res.sat  = 1'b0;
    res.data = r;
    if (r > hi) begin
      res.sat  = 1'b1;
      res.data = hi;
    end else if (r < lo) begin
      res.sat  = 1'b1;
      res.data = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/depthwise_mul_pipe.sv
// rtl/depthwise_mul_pipe.sv - staged signed activation x unsigned weight multiplier with valid chain
module depthwise_mul_pipe
  import depthwise_mac_pkg::*;
#(
  parameter int A_W        = DEF_A_W,
  parameter int B_W        = DEF_B_W,
  parameter int MUL_STAGES = DEF_MUL_STAGES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ce,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic signed [A_W-1:0]   in_a,
  input  logic [B_W-1:0]          in_b,
  output logic                    out_valid,
  output logic signed [A_W+B_W-1:0] out_p
);

  localparam int P_W = A_W + B_W;

  logic signed [A_W-1:0]  a_q;
  logic [B_W-1:0]         b_q;
  logic signed [P_W-1:0]  a_ext;
  logic signed [P_W-1:0]  b_ext;
  logic [MUL_STAGES-1:0]  v_q;
  logic signed [P_W-1:0]  p_q [MUL_STAGES-1];

  // The weight gets a zero sign bit so 63 stays +63; the true product fits P_W bits.
  assign a_ext = P_W'(a_q);
  assign b_ext = $signed(P_W'({1'b0, b_q}));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
    end else if (clr) begin
      v_q <= '0;
    end else if (ce) begin
      v_q <= {v_q[MUL_STAGES-2:0], in_valid};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < MUL_STAGES - 1; i++) begin
        p_q[i] <= '0;
      end
    end else if (ce) begin
      a_q    <= in_a;
      b_q    <= in_b;
      p_q[0] <= a_ext * b_ext;
      for (int i = 1; i < MUL_STAGES - 1; i++) begin
        p_q[i] <= p_q[i-1];
      end
    end
  end

  assign out_valid = v_q[MUL_STAGES-1];
  assign out_p     = p_q[MUL_STAGES-2];

endmodule

// File: rtl/depthwise_mac_pipe.sv
// rtl/depthwise_mac_pipe.sv - tap-accumulating MAC with round/shift/saturate and valid/ready backpressure
module depthwise_mac_pipe
  import depthwise_mac_pkg::*;
#(
  parameter int A_W        = DEF_A_W,
  parameter int B_W        = DEF_B_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int MUL_STAGES = DEF_MUL_STAGES,
  parameter int SHIFT      = DEF_SHIFT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             soft_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int P_W   = A_W + B_W;
  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  logic                    ce;
  logic                    mul_v;
  logic signed [P_W-1:0]   mul_p;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;
  logic [TAP_W-1:0]        tap_cnt;
  logic                    done_v;
  logic signed [ACC_W-1:0] sum_q;
  logic                    sum_v;
  rss_t                    rss;
  logic                    rss_unused;

  // A held result stalls every stage, bubbles included, so nothing is dropped or duplicated.
  assign ce       = ~out_valid | out_ready;
  assign in_ready = ce & ~soft_clr;

  depthwise_mul_pipe #(
    .A_W        (A_W),
    .B_W        (B_W),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .clr       (soft_clr),
    .in_valid  (in_valid & in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (mul_v),
    .out_p     (mul_p)
  );

  assign prod_ext = ACC_W'(mul_p);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap_cnt <= '0;
      acc     <= '0;
      done_v  <= 1'b0;
    end else if (soft_clr) begin
      tap_cnt <= '0;
      done_v  <= 1'b0;
    end else if (ce) begin
      done_v <= mul_v && (tap_cnt == LAST_TAP);
      if (mul_v) begin
        acc     <= (tap_cnt == '0) ? prod_ext : acc + prod_ext;
        tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + TAP_W'(1);
      end
    end
  end

  // Completed sum is latched so the accumulator can start the next group on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      sum_v <= 1'b0;
    end else if (soft_clr) begin
      sum_v <= 1'b0;
    end else if (ce) begin
      sum_v <= done_v;
      if (done_v) begin
        sum_q <= acc;
      end
    end
  end

  always_comb begin
    rss = round_shift_sat(RSS_W'(sum_q), ACC_W, OUT_W, SHIFT);
  end

  assign rss_unused = ^rss.data[RSS_W-1:OUT_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (soft_clr) begin
      out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= sum_v;
      if (sum_v) begin
        out_data <= rss.data[OUT_W-1:0];
        out_sat  <= rss.sat;
      end
    end
  end

endmodule

// File: tb/tb_depthwise_mac_pipe.sv
// tb/tb_depthwise_mac_pipe.sv - directed vector bench for depthwise_mac_pipe in four configurations
module tb_depthwise_mac_pipe;

  typedef struct {
    int    inst;
    int    n;
    int    a;
    int    b;
    int    exp_d;
    int    exp_s;
    string name;
  } vec_t;

  typedef struct {
    int inst;
    int data;
    int sat;
    int cyc;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic soft_clr = 1'b0;
  logic              iv   [4];
  logic signed [17:0] ia  [4];
  logic [5:0]        ib   [4];
  logic              ordy [4];
  logic              ir   [4];
  logic              ov   [4];
  logic signed [17:0] od  [4];
  logic              os   [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  rec_t recq [$];
  vec_t vecs [13];

  int bp_n;
  logic signed [17:0] bp_held;
  longint gsum;
  int exp_q [$];
  rec_t r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // inst 0: defaults (9 taps); 1: single tap; 2: single tap, SHIFT=2; 3: three taps
  depthwise_mac_pipe #(.NUM_TAPS(9), .SHIFT(0)) u_def (
    .clk(clk), .reset_n(reset_n), .soft_clr(soft_clr), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(ia[0]), .in_b(ib[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_sat(os[0]));
  depthwise_mac_pipe #(.NUM_TAPS(1), .SHIFT(0)) u_t1 (
    .clk(clk), .reset_n(reset_n), .soft_clr(soft_clr), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia[1]), .in_b(ib[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_sat(os[1]));
  depthwise_mac_pipe #(.NUM_TAPS(1), .SHIFT(2)) u_rnd (
    .clk(clk), .reset_n(reset_n), .soft_clr(soft_clr), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(ia[2]), .in_b(ib[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_sat(os[2]));
  depthwise_mac_pipe #(.NUM_TAPS(3), .SHIFT(0)) u_t3 (
    .clk(clk), .reset_n(reset_n), .soft_clr(soft_clr), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_a(ia[3]), .in_b(ib[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .out_sat(os[3]));

  always @(negedge clk) begin
    #4;
    for (int k = 0; k < 4; k++) begin
      if (reset_n && ov[k] && ordy[k]) begin
        recq.push_back('{inst: k, data: int'(od[k]), sat: int'(os[k]), cyc: cyc});
      end
    end
  end

  task automatic chk(input string nm, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_beat(input int k, input int a, input int b);
    int n;
    n = 0;
    @(negedge clk);
    iv[k] = 1'b1;
    ia[k] = a[17:0];
    ib[k] = b[5:0];
    #4;
    while (!ir[k] && n < 200) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (!ir[k]) begin
      checks++;
      errors++;
      $display("FAIL send_beat_inst%0d: in_ready stuck at 0 for 200 cycles", k);
    end
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
  endtask

  task automatic wait_result(input int k, input int ed, input int es, input string nm);
    int n;
    rec_t rr;
    n = 0;
    while (recq.size() == 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (recq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no result in 60 cycles, expected %0d", nm, ed);
    end else begin
      rr = recq.pop_front();
      chk({nm, "_inst"}, rr.inst, k);
      chk({nm, "_data"}, rr.data, ed);
      chk({nm, "_sat"}, rr.sat, es);
      chk({nm, "_latency"}, rr.cyc - last_acc, 5);
    end
    repeat (8) @(posedge clk);
    chk({nm, "_extra"}, recq.size(), 0);
  endtask

  function automatic int clamp18(input longint s);
    if (s > 131071) return 131071;
    if (s < -131072) return -131072;
    return int'(s);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0; ia[k] = '0; ib[k] = '0; ordy[k] = 1'b1;
    end
    vecs[0]  = '{1, 1, -1,      63, -63,     0, "unsigned_w"};
    vecs[1]  = '{1, 1, 0,       63, 0,       0, "zero_a"};
    vecs[2]  = '{1, 1, 2080,    63, 131040,  0, "below_max"};
    vecs[3]  = '{1, 1, 2081,    63, 131071,  1, "pos_clip_t1"};
    vecs[4]  = '{1, 1, -2081,   63, -131072, 1, "neg_clip_t1"};
    vecs[5]  = '{2, 1, 7,       1,  2,       0, "rnd_p7"};
    vecs[6]  = '{2, 1, -6,      1,  -1,      0, "rnd_m6"};
    vecs[7]  = '{2, 1, -2,      1,  0,       0, "rnd_half_neg"};
    vecs[8]  = '{2, 1, 6,       1,  2,       0, "rnd_half_pos"};
    vecs[9]  = '{2, 1, 131071,  63, 131071,  1, "rnd_clip"};
    vecs[10] = '{0, 9, 131071,  63, 131071,  1, "sat_pos"};
    vecs[11] = '{0, 9, -131072, 63, -131072, 1, "sat_neg"};
    vecs[12] = '{0, 9, 100,     3,  2700,    0, "group9"};

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("reset_out_valid", ov[k], 0);
      chk("reset_out_data", od[k], 0);
      chk("reset_out_sat", os[k], 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) chk("reset_in_ready", ir[k], 1);

    for (int v = 0; v < 13; v++) begin
      for (int t = 0; t < vecs[v].n; t++) send_beat(vecs[v].inst, vecs[v].a, vecs[v].b);
      wait_result(vecs[v].inst, vecs[v].exp_d, vecs[v].exp_s, vecs[v].name);
    end

    send_beat(3, 10, 5);
    send_beat(3, -20, 5);
    send_beat(3, 30, 5);
    wait_result(3, 100, 0, "basic3");

    // Backpressure: continuous stream, out_ready dropped for 10 cycles while a result is held
    recq.delete();
    fork
      begin
        for (int i = 0; i < 30; i++) send_beat(3, i * 37 - 500, i % 64);
      end
      begin
        bp_n = 0;
        repeat (10) @(negedge clk);
        #3;
        while (!ov[3] && bp_n < 50) begin
          @(negedge clk);
          #3;
          bp_n++;
        end
        chk("bp_valid_seen", ov[3], 1);
        ordy[3] = 1'b0;
        bp_held = od[3];
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          #3;
          chk("bp_hold_data", od[3], bp_held);
          chk("bp_in_ready", ir[3], 0);
          chk("bp_hold_valid", ov[3], 1);
        end
        ordy[3] = 1'b1;
      end
    join
    repeat (40) @(posedge clk);
    for (int g = 0; g < 10; g++) begin
      gsum = 0;
      for (int t = 0; t < 3; t++) gsum += longint'((g * 3 + t) * 37 - 500) * longint'((g * 3 + t) % 64);
      exp_q.push_back(clamp18(gsum));
    end
    chk("bp_result_count", recq.size(), 10);
    for (int g = 0; g < 10 && recq.size() > 0; g++) begin
      r = recq.pop_front();
      chk("bp_result_data", r.data, exp_q[g]);
      chk("bp_result_sat", r.sat, 0);
    end
    recq.delete();

    // Flush: partial group of 4, soft_clr with a beat offered, then a clean group
    for (int i = 0; i < 4; i++) send_beat(0, 1000, 1);
    @(negedge clk);
    soft_clr = 1'b1;
    iv[0] = 1'b1; ia[0] = 18'sd5000; ib[0] = 6'd1;
    #4;
    chk("clr_in_ready", ir[0], 0);
    @(negedge clk);
    soft_clr = 1'b0;
    iv[0] = 1'b0;
    gsum = 0;
    for (int i = 0; i < 9; i++) begin
      send_beat(0, 500 - i * 250, 2 * i + 3);
      gsum += longint'(500 - i * 250) * longint'(2 * i + 3);
    end
    wait_result(0, clamp18(gsum), 0, "after_clr");

    // Reset mid-group: two taps then asynchronous reset, then a full group
    for (int i = 0; i < 2; i++) send_beat(0, 2000, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_out_data", od[0], 0);
    chk("rst_out_valid", ov[0], 0);
    chk("rst_out_sat", os[0], 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", ir[0], 1);
    repeat (20) @(posedge clk);
    chk("flush_no_output", recq.size(), 0);
    gsum = 0;
    for (int i = 0; i < 9; i++) begin
      send_beat(0, i * 1000 - 3000, i + 1);
      gsum += longint'(i * 1000 - 3000) * longint'(i + 1);
    end
    wait_result(0, clamp18(gsum), 0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
